spi_result_tx: RTL
==================

# spi_result_tx

SPI-slave transmit path that returns mining results to the Raspberry Pi. Accepts a nonce/found result from the SHA-256 control FSM and holds it as a pending result. Serialises it MSB-first on `miso` when the Pi, acting as SPI master, runs a read transaction. This is the outbound counterpart of the inbound midstate/block-2 path. All SPI pins are oversampled in the `clk` domain; there is no logic clocked by `spi_clk`.

## Interface
Parameters:
- `NONCE_W`, default 32: result nonce width.
- `SYNC_STAGES`, default 2: synchroniser depth on `spi_clk` and `chip_enable`, minimum 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock. Must run at least 8× `spi_clk`.
- `rst` in 1: synchronous, active-high reset.
- `result_valid` in 1: result offered by the SHA-256 FSM.
- `result_nonce` in NONCE_W: winning or last-tried nonce.
- `result_found` in 1: 1 means the nonce meets the target.
- `result_ready` out 1: block can accept a result.
- `result_pending` out 1: a result is loaded and not yet fully read. Used as the request line to the Pi.
- `spi_clk` in 1: SPI clock from the Pi, mode 0 (idle low, master samples on rise).
- `chip_enable` in 1: SPI chip select, active-low.
- `miso` out 1: serial data to the Pi.
- `tx_busy` out 1: a frame is being shifted.
- `tx_done` out 1: one-cycle pulse when a complete frame has been read.

## Operation
- Frame length is F = 8 + NONCE_W bits, sent MSB first:
  - header byte `{7'b1010010, result_found}`, i.e. 0xA5 when found and 0xA4 when not found;
  - then `result_nonce`.
- Synchroniser: each of `spi_clk` and `chip_enable` passes through SYNC_STAGES flops. Edges are detected on the last two stages.
- Reset values of the synchroniser flops are the idle levels: `spi_clk` 0, `chip_enable` 1.
- `armed` flag: cleared by `rst`, set whenever the synchronised `chip_enable` is high. A CE fall starts a frame only if `armed` is set.
- State IDLE:
  - `result_ready`=1.
  - `result_valid` & `result_ready` loads the shift register with the frame, clears `bit_cnt`, and moves to LOADED.
  - A CE fall in IDLE is ignored; `miso` stays 0.
- State LOADED:
  - `result_pending`=1, `result_ready`=0.
  - A synchronised CE fall with `armed` set moves to SHIFT.
- State SHIFT:
  - `tx_busy`=1; `miso` = shift register MSB.
  - Synchronised `spi_clk` rise: `bit_cnt`++. When `bit_cnt` reaches F, move to DRAIN.
  - Synchronised `spi_clk` fall: shift left by one, filling with 0.
  - Synchronised CE rise before F rises (abort): reload the shift register from the held copy of the result, clear `bit_cnt`, return to LOADED. No `tx_done`. The Pi retries the read.
- State DRAIN:
  - `miso`=0 for any extra clocks.
  - Synchronised CE rise: pulse `tx_done` for one cycle, go to IDLE.
- `miso`=0 in every state except SHIFT.
- `result_valid` is ignored while `result_ready`=0. The producer holds the result until `result_ready` is seen.
- A CE fall and a load in the same IDLE cycle: the load wins and the CE fall is discarded. That transaction reads all zeros; the frame is sent on the next transaction.
- `rst` mid-frame: the result is discarded, all outputs take their reset values, and `armed` is cleared. An in-progress CE-low transaction reads zeros until CE goes high.

## Timing
- Reset values: `miso`=0, `result_ready`=0, `result_pending`=0, `tx_busy`=0, `tx_done`=0, state IDLE.
- `result_ready` rises the first cycle after `rst` deasserts.
- Load: `result_pending`=1 the cycle after the handshake.
- CE-fall to first bit on `miso`: SYNC_STAGES+1 `clk` after the pin edge. This must precede the first `spi_clk` rise, which the Pi's CS-to-clock delay guarantees.
- `spi_clk` fall to next bit on `miso`: at most SYNC_STAGES+1 `clk`. This is below half an SPI period given the 8× clock ratio.
- CE rise to `tx_done`: SYNC_STAGES+1 `clk`. `result_ready`=1 the cycle after `tx_done`.
- `result_pending` falls in the same cycle `tx_done` pulses.

## Test plan
- **Full frame, found.** Load nonce 0xDEADBEEF with found=1, run a 40-clock mode-0 read. Expect `miso` bits 0xA5DEADBEEF MSB first, one `tx_done` pulse after CE rise, then `result_ready`=1.
- **Full frame, not found.** Load nonce 0x00000001 with found=0. Expect 0xA400000001. `tx_busy` is high exactly from the CE fall to the 40th sampled rise.
- **Abort and retry.** CE rises after 12 clocks. Expect no `tx_done` and `result_pending` still 1. A second 40-clock read returns the complete 0xA5DEADBEEF.
- **Overrun and empty reads.**
  - 48-clock read: the last 8 bits are 0 and exactly one `tx_done` pulse occurs.
  - CE transaction in IDLE: `miso` is 0 throughout, no `tx_done`.
  - CE fall in the same cycle as the load: that transaction is all zeros and the next read returns the frame.
- **Backpressure.** Hold `result_valid` with a second nonce during LOADED and SHIFT. Expect `result_ready`=0 and no overwrite. The second nonce loads the cycle after `result_ready` returns.
- **Reset mid-frame.** Assert `rst` after 20 bits with CE held low. Expect all outputs at reset values and `miso`=0 for the remainder. A new load followed by a fresh CE transaction reads the full new frame.

Source files
------------

// File: rtl/spi_result_tx_if.sv
// Result handshake between the SHA-256 control FSM and the SPI result transmitter.
// Latency: none, this only bundles wires.
// Backpressure: the producer holds valid/nonce/found until it sees result_ready.
//   master : SHA-256 FSM side (drives result_valid/result_nonce/result_found)
//   slave  : spi_result_tx side (drives result_ready)
interface spi_result_tx_if #(
    parameter int NONCE_W = 32
) ();
    logic               result_valid;
    logic [NONCE_W-1:0] result_nonce;
    logic               result_found;
    logic               result_ready;

    modport master (
        output result_valid,
        output result_nonce,
        output result_found,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_nonce,
        input  result_found,
        output result_ready
    );
endinterface

// File: rtl/spi_result_tx.sv
// SPI-slave (mode 0) transmitter returning {header, nonce} results MSB first on miso.
// Latency: pin edge to action SYNC_STAGES+1 clk (synchroniser + registered edge pulse).
// Backpressure: result_ready is low from load until a full frame has been read out.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   res (slave)       result_valid/result_nonce/result_found in, result_ready out
//   result_pending    frame loaded and not yet completely read (request line to the Pi)
//   spi_clk, chip_enable  raw SPI pins, oversampled in clk (chip_enable active-low)
//   miso, tx_busy, tx_done  serial data, shifting flag, one-cycle frame-complete pulse
module spi_result_tx #(
    parameter int NONCE_W     = 32,
    parameter int SYNC_STAGES = 2    // must be at least 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_result_tx_if.slave   res,
    output logic             result_pending,
    input  logic             spi_clk,
    input  logic             chip_enable,
    output logic             miso,
    output logic             tx_busy,
    output logic             tx_done
);
    localparam int F     = 8 + NONCE_W;
    localparam int CNT_W = $clog2(F + 1);

    typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ce_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sclk_rise_q, sclk_fall_q;
    logic                   ce_rise_q, ce_fall_q;
    logic                   armed_q;
    logic [F-1:0]           shift_q, shift_d;
    logic [F-1:0]           held_q, held_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   pending_q, pending_d;
    logic                   done_q, done_d;
    logic                   load;

    // Synchronisers (newest sample at bit 0) and registered edge pulses taken
    // from the last two stages. fill_q marks when the chains hold real pin
    // samples rather than reset values, so a CE that is already low when
    // reset releases can never arm a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ce_sync_q   <= '1;
            fill_q      <= '0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ce_rise_q   <= 1'b0;
            ce_fall_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], chip_enable};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_rise_q <=  sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
            sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-2] &  sclk_sync_q[SYNC_STAGES-1];
            ce_rise_q   <=  ce_sync_q[SYNC_STAGES-2] & ~ce_sync_q[SYNC_STAGES-1];
            ce_fall_q   <= ~ce_sync_q[SYNC_STAGES-2] &  ce_sync_q[SYNC_STAGES-1];
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & ce_sync_q[SYNC_STAGES-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            held_q    <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            held_q    <= held_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    // ready_q is only ever set from an IDLE cycle without a load, so a
    // handshake always lands in IDLE.
    assign load = res.result_valid & ready_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A CE fall arriving together with a load is simply dropped.
                if (load) begin
                    shift_d = {7'b1010010, res.result_found, res.result_nonce};
                    held_d  = {7'b1010010, res.result_found, res.result_nonce};
                    cnt_d   = '0;
                    state_d = LOADED;
                end
            end
            LOADED: begin
                if (ce_fall_q && armed_q) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ce_rise_q) begin
                    // Aborted read: restore the frame so the Pi can retry.
                    shift_d = held_q;
                    cnt_d   = '0;
                    state_d = LOADED;
                end else begin
                    if (sclk_rise_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(F - 1)) begin
                            state_d = DRAIN;
                        end
                    end
                    if (sclk_fall_q) begin
                        shift_d = {shift_q[F-2:0], 1'b0};
                    end
                end
            end
            DRAIN: begin
                if (ce_rise_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered from the current state so ready returns the cycle after tx_done.
    assign ready_d   = (state_q == IDLE) & ~load;
    assign pending_d = (state_d != IDLE);

    assign res.result_ready = ready_q;
    assign result_pending   = pending_q;
    assign tx_done          = done_q;
    assign tx_busy          = (state_q == SHIFT);
    assign miso             = (state_q == SHIFT) & shift_q[F-1];
endmodule
